nexys_starship_repair: RTL
==========================

# nexys_starship_repair

Repair responder for the four starship sides. Monster state machines (TM, BM, LM, RM) raise per-side `broken` levels. This block then draws a random 4-bit repair code for each broken side. The player selects a side with the direction buttons and submits the code on switches Sw3..Sw0 with the centre button. On a correct entry the block pulses `repair_done` back to that side's monster SM, and it imposes a lockout after repeated wrong entries. It sits between the debounced button pulses, the monster SMs and the SSD mux in the top level.

## Interface
Parameters:
- `LFSR_SEED`, 16'hACE1, LFSR value loaded on reset; must be nonzero.
- `MAX_WRONG`, 3, number of consecutive wrong submissions that triggers lockout (1..3).
- `LOCKOUT_CYCLES`, 100_000_000, lockout length in `Clk` cycles (1 s at 100 MHz).

Ports:
- `Clk`  in  1  system clock (100 MHz `sys_clk`).
- `Reset`  in  1  synchronous, active-high reset.
- `play_flag`  in  1  game is in Play.
- `game_over`  in  1  game has ended.
- `broken`  in  4  level per side: {top, btm, left, right} = bits [3:0].
- `sel_pulse`  in  4  one-cycle select pulses {Up, Down, Left, Right} = bits [3:0].
- `submit_pulse`  in  1  one-cycle Center pulse.
- `combo_in`  in  4  {Sw3, Sw2, Sw1, Sw0}.
- `repair_done`  out  4  one-cycle pulse per side, same bit order as `broken`.
- `sel_side`  out  2  selected side: 0 top, 1 btm, 2 left, 3 right.
- `code_out`  out  4  required code of the selected side; 0 when that side is not BROKEN.
- `code_valid`  out  1  selected side is BROKEN.
- `locked`  out  1  lockout active.
- `wrong_count`  out  2  consecutive wrong submissions.

## Operation
LFSR:
- 16-bit Galois LFSR with polynomial mask 16'hB400.
- Shifts right every cycle and is never zero.
- Code sources: top = lfsr[15:12], btm = [11:8], left = [7:4], right = [3:0].

Per-side state machine:
- States are WORKING, BROKEN and REARM.
- WORKING -> BROKEN when `broken[i]` && `play_flag` && !`game_over`. The side's code is latched from its LFSR nibble on that edge.
- BROKEN -> REARM on an accepted submission for that side; `repair_done[i]` pulses for one cycle.
- REARM -> WORKING when `broken[i]` is low. While `broken[i]` stays high, no new code is latched.

Selection:
- A `sel_pulse` loads `sel_side`.
- If several bits are set, priority is top > btm > left > right.
- A selection in the same cycle as a submit takes effect after the submit: the submit uses the old `sel_side`.

Submission (`submit_pulse`, !`locked`, selected side BROKEN):
- `combo_in` == code: accept and clear `wrong_count`.
- Otherwise: increment `wrong_count`. When it reaches `MAX_WRONG`, set `locked`, load the lockout counter, and clear `wrong_count`.
- A submit while locked or on a non-BROKEN side is ignored and is not counted.

Lockout:
- `locked` stays high for exactly `LOCKOUT_CYCLES` cycles, then clears by itself.

`game_over`, or `play_flag` low:
- All sides go to WORKING and all codes clear to 0.
- `locked`, the lockout counter and `wrong_count` clear.
- `sel_side` goes to 0.
- `repair_done` is not asserted.
- This has priority over every other event in the same cycle.

## Timing
Reset values:
- All outputs are 0: `repair_done` 4'b0000, `sel_side` 0, `code_out` 0, `code_valid` 0, `locked` 0, `wrong_count` 0.
- All sides WORKING; LFSR = `LFSR_SEED`.

Latencies:
- `broken[i]` sampled high at edge N -> code stable and `code_valid` (if side i is selected) from cycle N+1.
- `submit_pulse` sampled at edge N -> `repair_done` high during cycle N+1 only. `wrong_count`/`locked` also update at N+1.
- `sel_pulse` at edge N -> `sel_side`, `code_out` and `code_valid` update at N+1. `code_out` and `code_valid` are combinational from `sel_side` and the side state.

Lockout and events:
- Lockout set at edge N -> `locked` high for cycles N+1 .. N+`LOCKOUT_CYCLES`.
- Simultaneous breaks on several sides latch independent nibbles in the same cycle.
- A submit to side A does not disturb side B's state or code.

## Test plan
Use `LOCKOUT_CYCLES`=8, `MAX_WRONG`=3, `LFSR_SEED`=16'hACE1 in the bench.

1. Reset -> all outputs 0 and LFSR = 16'hACE1; `broken`=4'b1111 while `play_flag`=0 -> no state change, `code_valid` stays 0.
2. `play_flag`=1, `broken`=4'b1000, `sel_pulse`=4'b1000, then read `code_out`=X. Submit `combo_in`=X -> `repair_done`=4'b1000 for exactly 1 cycle, `code_valid`=0, `wrong_count`=0.
3. Top broken, submit X^4'hF three times -> `wrong_count` 1, 2, then 0 with `locked`=1 for 8 cycles. A correct submit during lock gives no `repair_done`; a correct submit after lock clears gives `repair_done`=4'b1000.
4. `broken`=4'b0101 in one cycle and `sel_pulse`=4'b0101 -> `sel_side`=1. Codes equal the btm/right nibbles of the LFSR at the latch edge. Repairing btm leaves right BROKEN.
5. Right side broken with `wrong_count`=2, then `game_over`=1 -> all sides WORKING, `wrong_count`=0, `locked`=0, no `repair_done`.
6. After a repair, hold `broken[3]`=1 for 5 cycles -> no re-latch and `code_valid`=0. Drop it for 1 cycle, then raise it -> a new code is latched.

Source files
------------

// File: rtl/nexys_starship_repair.sv
// nexys_starship_repair: per-side repair-code responder with LFSR codes,
// side selection, code submission and a wrong-entry lockout.
module nexys_starship_repair #(
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          MAX_WRONG      = 3,
    parameter int          LOCKOUT_CYCLES = 100_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       game_over,
    input  logic [3:0] broken,
    input  logic [3:0] sel_pulse,
    input  logic       submit_pulse,
    input  logic [3:0] combo_in,
    output logic [3:0] repair_done,
    output logic [1:0] sel_side,
    output logic [3:0] code_out,
    output logic       code_valid,
    output logic       locked,
    output logic [1:0] wrong_count
);
    localparam int CW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {WORKING, BROKEN, REARM} side_t;

    side_t         state_q [4];
    side_t         state_d [4];
    logic [3:0]    code_q  [4];
    logic [3:0]    code_d  [4];
    logic [15:0]   lfsr_q, lfsr_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    wrong_q, wrong_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    done_q, done_d;
    logic          hold, take;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= '{default: WORKING};
            code_q   <= '{default: 4'h0};
            lfsr_q   <= LFSR_SEED;
            sel_q    <= '0;
            wrong_q  <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            lfsr_q   <= lfsr_d;
            sel_q    <= sel_d;
            wrong_q  <= wrong_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        hold     = !play_flag || game_over;
        take     = submit_pulse && !locked_q && state_q[sel_q] == BROKEN;
        state_d  = state_q;
        code_d   = code_q;
        sel_d    = ~|sel_pulse ? sel_q :
                   sel_pulse[3] ? 2'd0 : sel_pulse[2] ? 2'd1 : sel_pulse[1] ? 2'd2 : 2'd3;
        wrong_d  = wrong_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        done_d   = '0;
        // The counter is loaded with LOCKOUT_CYCLES-1 so locked spans exactly LOCKOUT_CYCLES cycles
        if (locked_q) begin
            cnt_d    = cnt_q - CW'(1);
            locked_d = cnt_q != '0;
        end
        for (int i = 0; i < 4; i++) begin
            if (state_q[i] == WORKING && broken[3-i]) begin
                state_d[i] = BROKEN;
                code_d[i]  = lfsr_q[15-4*i -: 4];
            end
            if (state_q[i] == REARM && !broken[3-i])
                state_d[i] = WORKING;
        end
        if (take) begin
            if (combo_in == code_q[sel_q]) begin
                state_d[sel_q] = REARM;
                done_d[~sel_q] = 1'b1;
                wrong_d        = '0;
            end else if (wrong_q == 2'(MAX_WRONG - 1)) begin
                wrong_d  = '0;
                locked_d = 1'b1;
                cnt_d    = CW'(LOCKOUT_CYCLES - 1);
            end else begin
                wrong_d = wrong_q + 2'd1;
            end
        end
        if (hold) begin
            state_d  = '{default: WORKING};
            code_d   = '{default: 4'h0};
            sel_d    = '0;
            wrong_d  = '0;
            locked_d = 1'b0;
            cnt_d    = '0;
            done_d   = '0;
        end
    end

    always_comb begin
        code_valid  = state_q[sel_q] == BROKEN;
        code_out    = code_valid ? code_q[sel_q] : 4'h0;
        repair_done = done_q;
        sel_side    = sel_q;
        locked      = locked_q;
        wrong_count = wrong_q;
    end
endmodule
